// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port word-addressed data memory between CPU (port 0) and DMA/debug (port 1).
// Optional per-port grant and conflict counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        gnt0,
   output logic        rvalid0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt1,
   output logic        rvalid1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] grant_cnt0,
   output logic [31:0] grant_cnt1,
   output logic [31:0] conflict_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [3:0]  BMAX    = 4'(BURST_MAX);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        g0, g1;
   logic        valid0, valid1;
   logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
   logic [31:0] rdata0_q, rdata1_q;
   logic [3:0]  cnt_inc;

   assign valid0  = (addr0[1:0] == 2'b00) && (addr0[31:2] < DEPTH_W);
   assign valid1  = (addr1[1:0] == 2'b00) && (addr1[31:2] < DEPTH_W);
   assign cnt_inc = (cnt_q >= BMAX) ? BMAX : cnt_q + 4'd1;

   // Invalid requests are still granted so they consume their slot; only the memory strobes are suppressed.
   always_comb begin
      g0      = 1'b0;
      g1      = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
      last_d  = last_q;
      if (!rst) begin
         if (req0 && req1) begin
            case (state_q)
               OWN0:    if (cnt_q < BMAX) g0 = 1'b1; else g1 = 1'b1;
               OWN1:    if (cnt_q < BMAX) g1 = 1'b1; else g0 = 1'b1;
               default: if (last_q) g0 = 1'b1; else g1 = 1'b1;
            endcase
         end else if (req0) begin
            g0 = 1'b1;
         end else if (req1) begin
            g1 = 1'b1;
         end
      end
      if (g0) begin
         state_d = OWN0;
         last_d  = 1'b0;
         cnt_d   = (state_q == OWN0) ? cnt_inc : 4'd1;
      end else if (g1) begin
         state_d = OWN1;
         last_d  = 1'b1;
         cnt_d   = (state_q == OWN1) ? cnt_inc : 4'd1;
      end
   end

   always_comb begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (g0) begin
         mem_address    = addr0;
         mem_write_data = wdata0;
         mem_write      = valid0 & we0;
         mem_read       = valid0 & ~we0;
      end else if (g1) begin
         mem_address    = addr1;
         mem_write_data = wdata1;
         mem_write      = valid1 & we1;
         mem_read       = valid1 & ~we1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= g0 & valid0 & ~we0;
         rvalid1_q <= g1 & valid1 & ~we1;
         err0_q    <= g0 & ~valid0;
         err1_q    <= g1 & ~valid1;
         if (g0 && valid0 && !we0) rdata0_q <= mem_read_data;
         if (g1 && valid1 && !we1) rdata1_q <= mem_read_data;
      end
   end

   assign gnt0    = g0;
   assign gnt1    = g1;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign err0    = err0_q;
   assign err1    = err1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] gcnt0_q, gcnt1_q, ccnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gcnt0_q <= '0;
         gcnt1_q <= '0;
         ccnt_q  <= '0;
      end else begin
         if (g0) gcnt0_q <= gcnt0_q + 32'd1;
         if (g1) gcnt1_q <= gcnt1_q + 32'd1;
         if (req0 && req1) ccnt_q <= ccnt_q + 32'd1;
      end
   end

   assign grant_cnt0   = gcnt0_q;
   assign grant_cnt1   = gcnt1_q;
   assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word-addressed data memory between two requesters: port 0 is the CPU load/store path, port 1 is a DMA/debug loader.
- Round-robin arbitration with a bounded burst length.
- A grant launches the memory access in the same cycle. Read data returns registered one cycle later.
- Sits between the requesters and the data memory, driving its mem_read, mem_write, address and write_data inputs and sampling read_data.

Parameters:
- DEPTH, 256, number of 32-bit words in the attached memory. Addresses with word index >= DEPTH are out of range.
- BURST_MAX, 4, maximum consecutive grants to one port while the other port is requesting. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until gnt0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  32  port 0 byte address
- wdata0  in  32  port 0 write data
- gnt0  out  1  port 0 access accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (one-cycle pulse)
- rdata0  out  32  port 0 read data
- err0  out  1  port 0 request rejected (one-cycle pulse, registered)
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same as port 0, for port 1
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_address  out  32  to memory
- mem_write_data  out  32  to memory
- mem_read_data  in  32  from memory (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, last_owner = 1 (so port 0 wins the first tie), burst_cnt = 0.
  - rvalid0/1 = 0, err0/1 = 0, rdata0/1 = 0.
  - gnt0/1 and mem_* are 0 while rst is high.
- State machine states: IDLE, OWN0, OWN1.
- Transitions, evaluated each cycle from current state and requests:
  - No valid request: grant none, next = IDLE, burst_cnt = 0.
  - Only one port requesting: grant it. next = OWNx. burst_cnt increments if x is the current owner, else loads 1.
  - Both requesting, state OWNx, burst_cnt < BURST_MAX: grant x, burst_cnt += 1.
  - Both requesting, state OWNx, burst_cnt == BURST_MAX: grant the other port y, next = OWNy, burst_cnt = 1.
  - Both requesting from IDLE: grant the port != last_owner.
  - last_owner updates to the granted port on every grant.
- burst_cnt saturates at BURST_MAX (4-bit).
- Error check: a request is invalid if addr[1:0] != 0 or addr[31:2] >= DEPTH.
  - An invalid request is still granted (gnt pulses, so it is consumed and arbitration slot used).
  - mem_read and mem_write stay 0 for it.
  - errx pulses 1 the next cycle; rvalidx stays 0.
- Memory side, granted valid access:
  - mem_address = addrx; mem_write_data = wdatax.
  - mem_write = wex; mem_read = !wex.
  - Exactly one of mem_read/mem_write high. Both are 0 when nothing is granted.
- Writes: commit at the rising edge ending the grant cycle. No response pulse.
- Reads: rdatax <= mem_read_data at that edge; rvalidx = 1 for exactly one cycle, the cycle after the grant.
  - rdatax holds its value until the next read on that port.
- Back-to-back: a port may receive grants on consecutive cycles. A read granted immediately after a write to the same address returns the new data.
- Reset mid-operation: an in-flight read response is discarded. rvalid/err are forced to 0 on the reset edge.
- gnt depends combinationally on req/addr; no combinational path from mem_read_data to gnt.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds outputs:
  - grant_cnt0 [31:0], grant_cnt1 [31:0]: grants per port.
  - conflict_cnt [31:0]: cycles with both req high.
  - All cleared by rst and wrap modulo 2^32.
- When undefined: the ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_read=mem_write=0, rvalid/err=0. First cycle after release: gnt0=1.
- Single port write then read:
  - Port 0 write addr 0x10 data 0xDEADBEEF -> gnt0=1, mem_write=1.
  - Next cycle, read 0x10 -> rvalid0=1 one cycle later with rdata0=0xDEADBEEF.
- Contention, BURST_MAX=4, both req held continuously -> grant sequence 0,0,0,0,1,1,1,1,0,...; conflict_cnt increments every cycle when DMEM_ARB_STATS_EN is defined.
- Errors:
  - Port 1 read addr 0x3 -> gnt1=1, mem_read=0, err1=1 next cycle, rvalid1=0.
  - Port 1 read addr 0x400 (DEPTH=256) -> same response.
- Alternation: req0 and req1 each pulse in alternate cycles -> each pulse granted immediately, no stalls, burst_cnt reloads to 1.
- Reset mid-read: grant a port 0 read, assert rst the next cycle -> rvalid0=0 and rdata0=0 after that edge.
